reg_file_mp: RTL and testbench

- Parametrised successor to the core register file, for the RISC-V datapath.
- Provides configurable word width, depth and number of read ports, plus one write port.
- Adds a hardwired-zero register 0, optional write-to-read bypass, and a post-reset clear sequencer that zeroes every entry and reports readiness.
- Sits between decode (read addresses) and writeback (write port).

---
 rtl/reg_file_mp_if.sv | 25 ++
 rtl/reg_file_mp.sv | 71 +++++++
 tb/tb_reg_file_mp.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Register file access bus: one write port plus NREAD flat-packed read ports.
// The register file (slave) drives ready and rd_data. Decode and writeback
// (master) drive the addresses and the write data.
interface reg_file_mp_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
);
    logic                     ready;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [XLEN-1:0]          wr_data;
    logic [NREAD*AW-1:0]      rd_addr;
    logic [NREAD*XLEN-1:0]    rd_data;

    modport master (
        input  ready, rd_data,
        output wr_en, wr_addr, wr_data, rd_addr
    );

    modport slave (
        output ready, rd_data,
        input  wr_en, wr_addr, wr_data, rd_addr
    );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised RISC-V register file: NREAD combinational read ports, one
// write port, and a hardwired-zero x0.
// After reset, a sweep zeroes entries 1..NREGS-1. ready stays low until the
// sweep is done, and reads return 0 while it runs.
module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_mp_if.slave  bus
);
    localparam logic [0:0]    CLEAR = 1'b0;
    localparam logic [0:0]    RUN   = 1'b1;
    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);
    // One extra bit so that a depth of exactly 2**AW is still representable.
    localparam logic [AW:0]   DEPTH = (AW + 1)'(NREGS);

    logic [0:0]      state;
    logic [AW-1:0]   clr_idx;
    logic            rdy;
    logic [XLEN-1:0] mem [NREGS];
    logic            wr_ok;

    // A write lands only in RUN, and only to an existing register other than x0.
    assign wr_ok = (state == RUN) && bus.wr_en && (bus.wr_addr != '0) &&
                   ({1'b0, bus.wr_addr} < DEPTH);

    // Sequencer: reset restarts the clear sweep at 1; the last index hands over to RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_idx <= AW'(1);
            rdy     <= 1'b0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == LAST) begin
                state <= RUN;
                rdy   <= 1'b1;
            end
        end
    end

    // Storage has a single write port, shared by the clear sweep and architectural writes.
    always_ff @(posedge clk) begin
        if (rst && state == CLEAR)
            mem[clr_idx] <= '0;
        else if (wr_ok)
            mem[bus.wr_addr] <= bus.wr_data;
    end

    assign bus.ready = rdy;

    // Every read port decodes its address independently. A same-cycle write
    // to the same register is forwarded only when BYPASS is set.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ok;
        logic          hit;

        assign ra  = bus.rd_addr[i*AW +: AW];
        assign ok  = (ra != '0) && ({1'b0, ra} < DEPTH);
        assign hit = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == ra);
        assign bus.rd_data[i*XLEN +: XLEN] = (state != RUN || !ok) ? '0 :
                                             hit                   ? bus.wr_data :
                                                                     mem[ra];
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. It builds three configurations:
//   u0: defaults, with bypass.
//   u1: BYPASS=0.
//   u2: NREGS=24, NREAD=3.
// All three share clk and rst.
module tb_reg_file_mp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    reg_file_mp_if #(.XLEN(32), .AW(5), .NREAD(2)) b0 ();
    reg_file_mp_if #(.XLEN(32), .AW(5), .NREAD(2)) b1 ();
    reg_file_mp_if #(.XLEN(32), .AW(5), .NREAD(3)) b2 ();

    reg_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    reg_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
    reg_file_mp #(.XLEN(32), .NREGS(24), .NREAD(3), .BYPASS(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

    // Inputs change 1 time unit after the rising edge and are sampled well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if (b0.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0b want 0", b0.ready); end
        rst = 1'b1;
        // Attempt a write to reg 5 for the whole sweep. It has to be dropped.
        b0.wr_en = 1'b1; b0.wr_addr = 5'd5; b0.wr_data = 32'hDEADBEEF;
        b0.rd_addr = {5'd7, 5'd5};
        for (int e = 1; e <= 31; e++) begin
            tick();
            n_vec++;
            if (b0.ready !== (e >= 31)) begin
                n_err++; $display("FAIL clear_ready edge %0d got %0b want %0b", e, b0.ready, e >= 31);
            end
            n_vec++;
            if (b2.ready !== (e >= 23)) begin
                n_err++; $display("FAIL npot_ready edge %0d got %0b want %0b", e, b2.ready, e >= 23);
            end
            if (e == 5 || e == 30) begin
                n_vec++;
                if (b0.rd_data !== 64'h0) begin
                    n_err++; $display("FAIL clear_read edge %0d got %h want 0", e, b0.rd_data);
                end
            end
        end
        b0.wr_en = 1'b0;
        #1;
        n_vec++;
        if (b0.rd_data[31:0] !== 32'h0) begin
            n_err++; $display("FAIL clear_dropped_write got %h want 0", b0.rd_data[31:0]);
        end
    endtask

    task automatic test_basic();
        b0.wr_en = 1'b1; b0.wr_addr = 5'd7; b0.wr_data = 32'h12345678;
        tick();
        b0.wr_en = 1'b0; b0.rd_addr = {5'd7, 5'd7};
        #1;
        n_vec++;
        if (b0.rd_data !== {32'h12345678, 32'h12345678}) begin
            n_err++; $display("FAIL basic_rd7 got %h want 1234567812345678", b0.rd_data);
        end
        b0.wr_en = 1'b1; b0.wr_addr = 5'd0; b0.wr_data = 32'hFFFFFFFF;
        tick();
        b0.wr_en = 1'b0; b0.rd_addr = {5'd0, 5'd0};
        #1;
        n_vec++;
        if (b0.rd_data !== 64'h0) begin
            n_err++; $display("FAIL basic_x0 got %h want 0", b0.rd_data);
        end
    endtask

    task automatic test_bypass();
        // u0 forwards the write; u1 returns the old value until the edge.
        b0.wr_en = 1'b1; b0.wr_addr = 5'd3; b0.wr_data = 32'hA;
        b1.wr_en = 1'b1; b1.wr_addr = 5'd3; b1.wr_data = 32'hA;
        tick();
        b0.wr_data = 32'hB; b0.rd_addr = {5'd7, 5'd3};
        b1.wr_data = 32'hB; b1.rd_addr = {5'd3, 5'd3};
        #1;
        n_vec++;
        if (b0.rd_data !== {32'h12345678, 32'hB}) begin
            n_err++; $display("FAIL bypass_on got %h want 12345678_0000000b", b0.rd_data);
        end
        n_vec++;
        if (b1.rd_data !== {32'hA, 32'hA}) begin
            n_err++; $display("FAIL bypass_off got %h want 0000000a_0000000a", b1.rd_data);
        end
        tick();
        b0.wr_en = 1'b0; b1.wr_en = 1'b0;
        #1;
        n_vec++;
        if (b0.rd_data[31:0] !== 32'hB) begin
            n_err++; $display("FAIL bypass_on_after got %h want b", b0.rd_data[31:0]);
        end
        n_vec++;
        if (b1.rd_data !== {32'hB, 32'hB}) begin
            n_err++; $display("FAIL bypass_off_after got %h want 0000000b_0000000b", b1.rd_data);
        end
    endtask

    task automatic test_mid_clear();
        b0.wr_en = 1'b1; b0.wr_addr = 5'd9; b0.wr_data = 32'h55;
        tick();
        b0.wr_en = 1'b0; b0.rd_addr = {5'd7, 5'd9};
        #1;
        n_vec++;
        if (b0.rd_data !== {32'h12345678, 32'h55}) begin
            n_err++; $display("FAIL mid_pre got %h want 12345678_00000055", b0.rd_data);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b0;   // the 10th edge of CLEAR samples reset
        tick();
        rst = 1'b1;
        n_vec++;
        if (b0.ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_rst got %0b want 0", b0.ready); end
        for (int e = 1; e <= 31; e++) begin
            tick();
            if (e == 30 || e == 31) begin
                n_vec++;
                if (b0.ready !== (e == 31)) begin
                    n_err++; $display("FAIL mid_ready edge %0d got %0b want %0b", e, b0.ready, e == 31);
                end
            end
        end
        n_vec++;
        if (b0.rd_data !== 64'h0) begin
            n_err++; $display("FAIL mid_cleared got %h want 0", b0.rd_data);
        end
    endtask

    task automatic test_npot();
        b2.wr_en = 1'b1; b2.wr_addr = 5'd1;  b2.wr_data = 32'h11111111;
        tick();
        b2.wr_addr = 5'd23; b2.wr_data = 32'h23232323;
        tick();
        b2.wr_addr = 5'd30; b2.wr_data = 32'h00000BAD;
        tick();
        b2.wr_en = 1'b0;
        b2.rd_addr = {5'd0, 5'd23, 5'd1};
        #1;
        n_vec++;
        if (b2.rd_data !== {32'h0, 32'h23232323, 32'h11111111}) begin
            n_err++; $display("FAIL npot_3port got %h want 00000000_23232323_11111111", b2.rd_data);
        end
        b2.rd_addr = {5'd30, 5'd30, 5'd30};
        #1;
        n_vec++;
        if (b2.rd_data !== 96'h0) begin
            n_err++; $display("FAIL npot_oob got %h want 0", b2.rd_data);
        end
        // An out-of-range write must also not bypass onto an out-of-range read.
        b2.wr_en = 1'b1;
        #1;
        n_vec++;
        if (b2.rd_data !== 96'h0) begin
            n_err++; $display("FAIL npot_oob_bypass got %h want 0", b2.rd_data);
        end
        b2.wr_en = 1'b0;
    endtask

    initial begin
        b0.wr_en = 1'b0; b0.wr_addr = '0; b0.wr_data = '0; b0.rd_addr = '0;
        b1.wr_en = 1'b0; b1.wr_addr = '0; b1.wr_data = '0; b1.rd_addr = '0;
        b2.wr_en = 1'b0; b2.wr_addr = '0; b2.wr_data = '0; b2.rd_addr = '0;
        test_reset();
        test_basic();
        test_bypass();
        test_mid_clear();
        test_npot();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
